// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_if
// Brief  : Instruction-memory and IF/ID handshake bundle for the fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;

    modport master (
        output imem_req, imem_addr, id_inst, id_pc, id_valid,
        input  imem_rdata, imem_rvalid, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_inst, id_pc, id_valid,
        output imem_rdata, imem_rvalid, stall, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Brief  : RV32I instruction fetch: PC, single-outstanding imem fetch, IF/ID.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic        clock,
    input  wire logic        reset,
    fetch_stage_if.master    bus,
    output logic [31:0]      pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;
    logic        r_id_valid;

    logic        w_load;
    logic [31:0] w_load_inst;
    logic [31:0] w_load_pc;
    logic [31:0] w_pc_seq;
    logic [31:0] w_redirect_tgt;

    assign w_pc_seq       = r_pc + 32'd4;
    assign w_redirect_tgt = bus.redirect_pc & ~32'd3;

    assign bus.imem_req  = (r_state == S_FETCH) && reset;
    assign bus.imem_addr = r_pc;
    assign bus.id_inst   = r_id_inst;
    assign bus.id_pc     = r_id_pc;
    assign bus.id_valid  = r_id_valid;
    assign pc            = r_pc;

    // Which word (if any) enters IF/ID this cycle, ignoring redirect.
    always_comb begin
        w_load      = 1'b0;
        w_load_inst = r_hold_inst;
        w_load_pc   = r_hold_pc;
        case (r_state)
            S_WAIT: begin
                if (bus.imem_rvalid && !r_kill && !bus.stall) begin
                    w_load      = 1'b1;
                    w_load_inst = bus.imem_rdata;
                    w_load_pc   = r_pc;
                end
            end
            S_HOLD: begin
                if (!bus.stall) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_hold_inst <= 32'd0;
            r_hold_pc   <= 32'd0;
            r_id_inst   <= NOP_INST;
            r_id_pc     <= 32'd0;
            r_id_valid  <= 1'b0;
        end else if (bus.redirect) begin
            r_pc       <= w_redirect_tgt;
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
            case (r_state)
                S_FETCH: begin
                    // The request issued this cycle belongs to the old path.
                    r_state <= S_WAIT;
                    r_kill  <= 1'b1;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_state <= S_FETCH;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_FETCH;
                    r_hold_inst <= 32'd0;
                    r_hold_pc   <= 32'd0;
                end
            endcase
        end else begin
            if (w_load) begin
                r_id_inst  <= w_load_inst;
                r_id_pc    <= w_load_pc;
                r_id_valid <= 1'b1;
                r_pc       <= w_pc_seq;
            end else if (!bus.stall) begin
                r_id_inst  <= NOP_INST;
                r_id_valid <= 1'b0;
            end

            case (r_state)
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_FETCH;
                        end else if (!bus.stall) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_hold_inst <= bus.imem_rdata;
                            r_hold_pc   <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage RV32I pipeline.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Drives the IF/ID pipeline register that feeds the decode/control stage.
- Handles decode stall (hold) and taken-branch/jump redirect (flush, discard of in-flight fetch).

Parameters:
RESET_PC, 32'h0100_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction word driven on id_inst when the IF/ID slot is empty (addi x0,x0,0)

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request, accepted by memory in the cycle it is high
imem_addr  output  32  fetch address, equal to pc while imem_req=1
imem_rdata  input  32  returned instruction word
imem_rvalid  input  1  imem_rdata valid; earliest one cycle after imem_req
stall  input  1  decode cannot accept; hold IF/ID contents
redirect  input  1  taken branch/jump (brn_tkn from decode)
redirect_pc  input  32  redirect target
id_inst  output  32  IF/ID instruction
id_pc  output  32  IF/ID PC of id_inst
id_valid  output  1  IF/ID slot holds a real instruction
pc  output  32  current fetch PC (debug/trace)

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=FETCH, kill=0, hold_buf=0, imem_req=0, imem_addr=RESET_PC, id_inst=NOP_INST, id_pc=0, id_valid=0.
- imem_req is a combinational decode of state: 1 only in FETCH while reset=1. imem_addr=pc at all times.
- FETCH: imem_req=1; next state WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - kill=1: drop the word, clear kill, go to FETCH.
  - stall=0: load id_inst=imem_rdata, id_pc=pc, id_valid=1; pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 -> 0); go to FETCH.
  - stall=1: capture the word and its pc in hold_buf; go to HOLD.
  - Without rvalid, remain in WAIT indefinitely.
- HOLD: imem_req=0. When stall=0: load IF/ID from hold_buf, id_valid=1, pc<=pc+4, go to FETCH.
- imem_rvalid outside WAIT is ignored.
- IF/ID update rules:
  - stall=1: id_inst, id_pc and id_valid hold.
  - stall=0 with no load this cycle: id_valid<=0, id_inst<=NOP_INST, id_pc holds.
- Redirect has priority over stall and over all state actions:
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - id_valid<=0, id_inst<=NOP_INST.
  - In FETCH: the request just issued is stale; go to WAIT with kill=1.
  - In WAIT: kill<=1; a word returning in the same cycle is also dropped (kill stays 1 only if rvalid was not high).
  - In HOLD: discard hold_buf, go to FETCH.
- Throughput: at most one instruction per 2 cycles (FETCH then WAIT with rvalid). Fetch-to-id_valid latency is 2 cycles minimum.
- Reset mid-operation aborts any outstanding request. A word returned after reset deasserts while in FETCH is ignored.

Test Plan:
- Reset release with 1-cycle memory and stall=0: imem_addr sequence 0x01000000, 0x01000004, 0x01000008; id_pc follows 2 cycles behind each fetch with id_valid=1; id_inst matches memory.
- Stall=1 for 3 cycles while the word for 0x01000004 returns: state=HOLD, IF/ID unchanged, no imem_req. After stall drops, id_inst is the 0x01000004 word, then fetch of 0x01000008 resumes.
- Redirect=1 to 0x01000043 in WAIT, with rvalid arriving the next cycle: the returned word is dropped, id_valid=0, and the next imem_addr is 0x01000040.
- Redirect and stall both high in the same cycle: id_valid=0, id_inst=0x00000013, pc=redirect_pc.
- 3-cycle memory latency: imem_req pulses for 1 cycle per fetch and stays 0 during the wait; each instruction is loaded exactly once.
- Assert reset while in WAIT: outputs return to reset values immediately. After release, a stale rvalid is ignored and fetch restarts at 0x01000000.
